id_operand_stage: RTL and testbench

- Instruction-decode/operand-fetch pipeline stage of the RV32I core; sits directly upstream of the register file and feeds the execute stage.
- Accepts one instruction per cycle over valid/ready and decodes fields and immediate.
- Drives the register file read addresses and aligns the 1-cycle registered operands with the decoded control.
- Forwards same-edge writeback data that the register file read misses.

---
 rtl/rv32i_pkg.sv | 60 ++++++
 rtl/rv32i_imm_gen.sv | 32 +++
 rtl/id_operand_stage.sv | 145 ++++++++++++++
 tb/tb_id_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcodes, opcode classes and immediate-type codes shared by decode.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef logic [3:0] opclass_t;

  localparam opclass_t CLS_LUI     = 4'd0;
  localparam opclass_t CLS_AUIPC   = 4'd1;
  localparam opclass_t CLS_JAL     = 4'd2;
  localparam opclass_t CLS_JALR    = 4'd3;
  localparam opclass_t CLS_BRANCH  = 4'd4;
  localparam opclass_t CLS_LOAD    = 4'd5;
  localparam opclass_t CLS_STORE   = 4'd6;
  localparam opclass_t CLS_OPIMM   = 4'd7;
  localparam opclass_t CLS_OP      = 4'd8;
  localparam opclass_t CLS_FENCE   = 4'd9;
  localparam opclass_t CLS_SYSTEM  = 4'd10;
  localparam opclass_t CLS_ILLEGAL = 4'd15;

  typedef logic [2:0] imm_type_t;

  localparam imm_type_t IMM_NONE = 3'd0;
  localparam imm_type_t IMM_I    = 3'd1;
  localparam imm_type_t IMM_S    = 3'd2;
  localparam imm_type_t IMM_B    = 3'd3;
  localparam imm_type_t IMM_U    = 3'd4;
  localparam imm_type_t IMM_J    = 3'd5;

  // Opcodes with instr[1:0] != 2'b11 never match a listed opcode, so they land on ILLEGAL too.
  function automatic opclass_t opcode_class(input logic [6:0] opc);
    opclass_t cls;
    case (opc)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// rtl/rv32i_imm_gen.sv - combinational RV32I immediate extraction, sign-extended from instr[31].
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_type_t   imm_type
);

  always_comb begin
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:                                 imm_type = IMM_S;
      OPC_BRANCH:                                imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:                        imm_type = IMM_U;
      OPC_JAL:                                   imm_type = IMM_J;
      default:                                   imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - RV32I decode/operand-fetch stage with valid/ready handshake.
// ID_WB_BYPASS_EN adds same-edge writeback forwarding onto the registered operands.
module id_operand_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [RA_W-1:0] rf_rs1,
  output logic [RA_W-1:0] rf_rs2,
  input  logic [XLEN-1:0] rf_a,
  input  logic [XLEN-1:0] rf_b,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [RA_W-1:0] out_rd,
  output logic [3:0]      out_opclass,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state;
  logic            accept;
  logic [RA_W-1:0] rs1_q;
  logic [RA_W-1:0] rs2_q;
  logic [31:0]     dec_imm;
  imm_type_t       dec_imm_type;
  opclass_t        dec_class;
  logic            dec_illegal;
  logic            unused_imm_type;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Steering the read port to the incoming word lets the registered read land with the instruction.
  assign rf_rs1 = accept ? in_instr[19:15] : rs1_q;
  assign rf_rs2 = accept ? in_instr[24:20] : rs2_q;

  rv32i_imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_imm_type)
  );

  assign unused_imm_type = ^dec_imm_type;

  always_comb begin
    dec_class   = opcode_class(in_instr[6:0]);
    dec_illegal = (dec_class == CLS_ILLEGAL);
    if (dec_class == CLS_OP && in_instr[31:25] != 7'h00 && in_instr[31:25] != 7'h20) begin
      dec_illegal = 1'b1;
    end
    if (dec_class == CLS_OP && in_instr[31:25] == 7'h20 &&
        in_instr[14:12] != 3'b000 && in_instr[14:12] != 3'b101) begin
      dec_illegal = 1'b1;
    end
    if (dec_illegal) begin
      dec_class = CLS_ILLEGAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      rs1_q        <= '0;
      rs2_q        <= '0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_opclass  <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      if (flush) begin
        state <= EMPTY;
      end else if (accept) begin
        state <= FULL;
      end else if (state == FULL && out_ready) begin
        state <= EMPTY;
      end
      if (accept && !flush) begin
        rs1_q        <= in_instr[19:15];
        rs2_q        <= in_instr[24:20];
        out_pc       <= in_pc;
        out_imm      <= dec_imm;
        out_rd       <= in_instr[11:7];
        out_opclass  <= dec_class;
        out_funct3   <= in_instr[14:12];
        out_funct7b5 <= in_instr[30];
        out_illegal  <= dec_illegal;
      end
    end
  end

`ifdef ID_WB_BYPASS_EN
  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] byp1_data;
  logic [XLEN-1:0] byp2_data;

  // The register file reads the old value on a same-edge write; remember the write instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp1      <= 1'b0;
      byp2      <= 1'b0;
      byp1_data <= '0;
      byp2_data <= '0;
    end else begin
      byp1      <= wb_en && (wb_rd == rf_rs1) && (rf_rs1 != '0);
      byp2      <= wb_en && (wb_rd == rf_rs2) && (rf_rs2 != '0);
      byp1_data <= wb_data;
      byp2_data <= wb_data;
    end
  end

  assign out_rs1_val = (rs1_q == '0) ? '0 : (byp1 ? byp1_data : rf_a);
  assign out_rs2_val = (rs2_q == '0) ? '0 : (byp2 ? byp2_data : rf_b);
`else
  logic unused_wb;

  assign unused_wb   = ^{wb_en, wb_rd, wb_data};
  assign out_rs1_val = (rs1_q == '0) ? '0 : rf_a;
  assign out_rs2_val = (rs2_q == '0) ? '0 : rf_b;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - self-checking bench for id_operand_stage with a behavioural register file.
module tb_id_operand_stage;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_a, rf_b, wb_data;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd, out_rd;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [3:0]  out_opclass;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal;

  logic [31:0] rf_mem [32];
  logic [31:0] arch [32];
  logic [31:0] arch_prev [32];
  bit          exp_valid;
  logic [31:0] exp_instr, exp_pc;
  int          checks, failures;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_a(rf_a), .rf_b(rf_b),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_opclass(out_opclass), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  // Register file: one-cycle registered read that returns the pre-write value on a same-edge write.
  always @(posedge clk) begin
    rf_a <= rf_mem[rf_rs1];
    rf_b <= rf_mem[rf_rs2];
    if (wb_en && wb_rd != 5'd0) rf_mem[wb_rd] <= wb_data;
  end

  function automatic logic [3:0] ref_class(input logic [31:0] i);
    logic [3:0] c;
    case (i[6:0])
      7'h37: c = 4'd0;   7'h17: c = 4'd1;  7'h6F: c = 4'd2;  7'h67: c = 4'd3;
      7'h63: c = 4'd4;   7'h03: c = 4'd5;  7'h23: c = 4'd6;  7'h13: c = 4'd7;
      7'h33: c = 4'd8;   7'h0F: c = 4'd9;  7'h73: c = 4'd10; default: c = 4'd15;
    endcase
    if (c == 4'd8 && !(i[31:25] == 7'h00 || i[31:25] == 7'h20)) c = 4'd15;
    if (c == 4'd8 && i[31:25] == 7'h20 && !(i[14:12] == 3'b000 || i[14:12] == 3'b101)) c = 4'd15;
    return c;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int s, v;
    s = i[31] ? 1 : 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: v = -2048 * s + int'(i[30:20]);
      7'h23: v = -2048 * s + 32 * int'(i[30:25]) + int'(i[11:7]);
      7'h63: v = -4096 * s + 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
      7'h37, 7'h17: v = int'(i & 32'hFFFFF000);
      7'h6F: v = -1048576 * s + 4096 * int'(i[19:12]) + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
      default: v = 0;
    endcase
    return v;
  endfunction

  // With forwarding the operand is the current architectural value; without it, the value before the last edge.
  function automatic logic [31:0] ref_operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    return BYP ? arch[r] : arch_prev[r];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  opc;
    int          k;
    k = $urandom_range(0, 11);
    case (k)
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8: opc = 7'h33;  9: opc = 7'h0F;  10: opc = 7'h73; default: opc = 7'($urandom);
    endcase
    i = $urandom;
    i[6:0]   = opc;
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    if (opc == 7'h33) begin
      k = $urandom_range(0, 3);
      if (k == 0) i[31:25] = 7'h00;
      else if (k == 1) i[31:25] = 7'h20;
    end else if (i[31:25] == 7'h20) begin
      i[25] = 1'b1;
    end
    return i;
  endfunction

  task automatic step();
    bit acc;
    acc = in_valid && (!exp_valid || out_ready);
    @(posedge clk);
    arch_prev = arch;
    if (wb_en && wb_rd != 5'd0) arch[wb_rd] = wb_data;
    if (reset || flush) exp_valid = 1'b0;
    else if (acc) begin
      exp_valid = 1'b1;
      exp_instr = in_instr;
      exp_pc    = in_pc;
    end else if (exp_valid && out_ready) exp_valid = 1'b0;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = r; wb_data = v;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h40; out_ready = 1'b1;
    for (int r = 1; r < 32; r++) begin
      wb_en = 1'b1; wb_rd = 5'(r); wb_data = $urandom;
      step();
    end
    wb_en = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_rs1_val !== 32'd0) begin failures++; $display("FAIL reset_rs1: got %h want 0", out_rs1_val); end
    checks++; if (out_imm !== 32'd0) begin failures++; $display("FAIL reset_imm: got %h want 0", out_imm); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_decode();
    write_reg(5'd2, 32'd5);
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL decode_valid: got %b want 1", out_valid); end
    checks++; if (out_opclass !== 4'd7) begin failures++; $display("FAIL decode_class: got %0d want 7", out_opclass); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL decode_imm: got %h want ffffffff", out_imm); end
    checks++; if (out_rs1_val !== 32'd5) begin failures++; $display("FAIL decode_rs1: got %h want 5", out_rs1_val); end
    checks++; if (out_rd !== 5'd1) begin failures++; $display("FAIL decode_rd: got %0d want 1", out_rd); end
    checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL decode_pc: got %h want 100", out_pc); end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h104; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL branch_imm: got %h want fffffffc", out_imm); end
    checks++; if (out_opclass !== 4'd4) begin failures++; $display("FAIL branch_class: got %0d want 4", out_opclass); end
    checks++; if (out_rs1_val !== 32'd0) begin failures++; $display("FAIL branch_x0: got %h want 0", out_rs1_val); end
  endtask

  task automatic test_bypass();
    write_reg(5'd1, 32'h11111111);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h108; out_ready = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    step();
    wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_rs1_val !== (BYP ? 32'hDEADBEEF : 32'h11111111)) begin
      failures++; $display("FAIL bypass_rs1: got %h want %h", out_rs1_val, BYP ? 32'hDEADBEEF : 32'h11111111); end
    checks++; if (out_rs2_val !== 32'd5) begin failures++; $display("FAIL bypass_rs2: got %h want 5", out_rs2_val); end
    checks++; if (out_opclass !== 4'd8) begin failures++; $display("FAIL bypass_class: got %0d want 8", out_opclass); end
    step();
    checks++; if (out_rs1_val !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_settled: got %h want deadbeef", out_rs1_val); end
  endtask

  task automatic test_stall_late_write();
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_instr = 32'hFFF10093; in_pc = 32'h300;
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234;
    step();
    wb_en = 1'b0;
    checks++; if (out_rs2_val !== (BYP ? 32'h1234 : 32'd5)) begin
      failures++; $display("FAIL stall_rs2_early: got %h want %h", out_rs2_val, BYP ? 32'h1234 : 32'd5); end
    step();
    checks++; if (out_rs2_val !== 32'h1234) begin failures++; $display("FAIL stall_rs2: got %h want 1234", out_rs2_val); end
    checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL stall_pc: got %h want 200", out_pc); end
    checks++; if (out_rd !== 5'd3) begin failures++; $display("FAIL stall_rd: got %0d want 3", out_rd); end
    checks++; if (out_rs1_val !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_rs1: got %h want deadbeef", out_rs1_val); end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_illegal();
    in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h400; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL illegal_valid: got %b want 1", out_valid); end
    checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag: got %b want 1", out_illegal); end
    checks++; if (out_opclass !== 4'd15) begin failures++; $display("FAIL illegal_class: got %0d want 15", out_opclass); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h1000 + 32'(4 * k);
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(4 * k)) begin
        failures++; $display("FAIL b2b_%0d: got valid=%b pc=%h want valid=1 pc=%h", k, out_valid, out_pc, 32'h1000 + 32'(4 * k)); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = $urandom_range(0, 1) == 1;
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      in_instr  = rand_instr();
      in_pc     = $urandom;
      step();
      checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, exp_valid); end
      checks++; if (in_ready !== (!exp_valid || out_ready)) begin
        failures++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, !exp_valid || out_ready); end
      if (exp_valid) begin
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, out_pc, exp_pc); end
        e = ref_imm(exp_instr);
        checks++; if (out_imm !== e) begin failures++; $display("FAIL rnd_imm[%0d]: instr %h got %h want %h", n, exp_instr, out_imm, e); end
        checks++; if (out_opclass !== ref_class(exp_instr)) begin
          failures++; $display("FAIL rnd_class[%0d]: instr %h got %0d want %0d", n, exp_instr, out_opclass, ref_class(exp_instr)); end
        checks++; if (out_illegal !== (ref_class(exp_instr) == 4'd15)) begin
          failures++; $display("FAIL rnd_illegal[%0d]: instr %h got %b", n, exp_instr, out_illegal); end
        checks++; if ({out_rd, out_funct3, out_funct7b5} !== {exp_instr[11:7], exp_instr[14:12], exp_instr[30]}) begin
          failures++; $display("FAIL rnd_fields[%0d]: got %h want %h", n, {out_rd, out_funct3, out_funct7b5}, {exp_instr[11:7], exp_instr[14:12], exp_instr[30]}); end
        e = ref_operand(exp_instr[19:15]);
        checks++; if (out_rs1_val !== e) begin failures++; $display("FAIL rnd_rs1[%0d]: got %h want %h", n, out_rs1_val, e); end
        e = ref_operand(exp_instr[24:20]);
        checks++; if (out_rs2_val !== e) begin failures++; $display("FAIL rnd_rs2[%0d]: got %h want %h", n, out_rs2_val, e); end
      end
    end
    flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h500; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_load: got %b want 1", out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready: got %b want 1", in_ready); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL mid_reset_pc: got %h want 0", out_pc); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_valid = 1'b0; exp_instr = '0; exp_pc = '0;
    for (int r = 0; r < 32; r++) begin arch[r] = 32'd0; arch_prev[r] = 32'd0; end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    #1;
    test_reset();
    test_decode();
    test_branch();
    test_bypass();
    test_stall_late_write();
    test_flush_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
